// File: rtl/data_mem_param_if.sv
// Request/response bundle for data_mem_param: valid/ready request channel plus the
// registered read-response signals. The master drives requests; the memory is the slave.
interface data_mem_param_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) ();
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              par_inject;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              addr_err;
  logic              parity_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, par_inject,
    input  req_ready, rsp_valid, rsp_rdata, addr_err, parity_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, par_inject,
    output req_ready, rsp_valid, rsp_rdata, addr_err, parity_err
  );
endinterface

// File: rtl/data_mem_param.sv
// Single-port DATA_W x DEPTH data memory with a self-initialising sweep, 1-cycle registered
// reads and out-of-range flagging. Define DATA_MEM_PARITY_EN to store and check per-word even parity.
module data_mem_param #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int DEPTH     = 64,
  parameter int INIT_MODE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            init_req,
  output logic            busy,
  data_mem_param_if.slave bus
);

  localparam int                IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0]  CNT_LAST = IDX_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W + 1)'(DEPTH);
`ifdef DATA_MEM_PARITY_EN
  localparam int                MEM_W    = DATA_W + 1;
`else
  localparam int                MEM_W    = DATA_W;
`endif

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic              req_ready;

  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              addr_err_q, addr_err_d;
  logic              parity_err_q, parity_err_d;

  logic [MEM_W-1:0]  mem_q [DEPTH];

  logic [IDX_W-1:0]  idx;
  logic              in_range;
  logic              acc;
  logic              wr_en;
  logic              rd_en;
  logic [DATA_W-1:0] init_data;
  logic [MEM_W-1:0]  init_word;
  logic [MEM_W-1:0]  wr_word;
  logic [MEM_W-1:0]  rd_word;
  logic              rd_par_bad;

  // Widening the address by one bit keeps DEPTH == 2**ADDR_W representable.
  assign idx      = bus.req_addr[IDX_W-1:0];
  assign in_range = ({1'b0, bus.req_addr} < DEPTH_X);
  assign acc      = bus.req_valid && req_ready;
  assign wr_en    = acc && bus.req_we && in_range;
  assign rd_en    = acc && !bus.req_we;

  assign init_data = (INIT_MODE != 0) ? DATA_W'(cnt_q) : '0;
  assign rd_word   = mem_q[idx];

`ifdef DATA_MEM_PARITY_EN
  function automatic logic even_par(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

  assign init_word  = {even_par(init_data), init_data};
  assign wr_word    = {even_par(bus.req_wdata) ^ bus.par_inject, bus.req_wdata};
  assign rd_par_bad = (even_par(rd_word[DATA_W-1:0]) != rd_word[DATA_W]);
`else
  logic unused_par_inject;

  assign init_word         = init_data;
  assign wr_word           = bus.req_wdata;
  assign rd_par_bad        = 1'b0;
  assign unused_par_inject = bus.par_inject;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: the sweep visits every word once, then hands over to RUN
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_INIT: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + IDX_W'(1);
        end
      end
      ST_RUN: begin
        if (init_req) begin
          state_d = ST_INIT;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = '0;
      end
    endcase
  end

  // Output logic: init_req blocks acceptance in the same cycle it is seen
  always_comb begin
    busy      = 1'b0;
    req_ready = 1'b0;
    case (state_q)
      ST_INIT: busy      = 1'b1;
      ST_RUN:  req_ready = !init_req;
      default: busy      = 1'b1;
    endcase
  end

  // Storage: sweep writes and accepted in-range writes; reset has priority over both
  always_ff @(posedge clk) begin
    if (rst_n && (state_q == ST_INIT)) begin
      mem_q[cnt_q] <= init_word;
    end else if (rst_n && wr_en) begin
      mem_q[idx] <= wr_word;
    end
  end

  // Read response next-state; rdata holds between responses
  always_comb begin
    rsp_valid_d  = rd_en;
    addr_err_d   = rd_en && !in_range;
    parity_err_d = rd_en && in_range && rd_par_bad;
    rsp_rdata_d  = rsp_rdata_q;
    if (rd_en) begin
      rsp_rdata_d = in_range ? rd_word[DATA_W-1:0] : '0;
    end
  end

  // Response register stage
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      addr_err_q   <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      addr_err_q   <= addr_err_d;
      parity_err_q <= parity_err_d;
    end
  end

  assign bus.req_ready  = req_ready;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_rdata  = rsp_rdata_q;
  assign bus.addr_err   = addr_err_q;
  assign bus.parity_err = parity_err_q;

endmodule
